// File: rtl/adc_serial_responder.sv
// adc_serial_responder
//   Device end of the 8-channel serial ADC link. Synchronizes the master's
//   CS_N / SCLK / SADDR pins and detects their edges. It captures the 3-bit
//   channel address on SCLK rises 3..5. It shifts a FRAME_BITS-wide word,
//   made of leading zeros and then the DATA_W-bit sample, MSB first on ADC_SDAT.
//   The address decoded in one frame selects the channel returned in the next.
//   SYNC_STAGES must be at least 2: edges compare the last two stages.

module adc_serial_responder #(
    parameter int DATA_W      = 12,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ADC_CS_N,
    input  logic                  ADC_SCLK,
    input  logic                  ADC_SADDR,
    input  logic [8*DATA_W-1:0]   ch_data,
    output logic                  ADC_SDAT,
    output logic [2:0]            cur_ch,
    output logic [2:0]            next_ch,
    output logic                  frame_active,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int PAD_W = FRAME_BITS - DATA_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Build a frame word: zero padding followed by the selected channel sample.
    function automatic logic [FRAME_BITS-1:0] load_word(
        input logic [8*DATA_W-1:0] data,
        input logic [2:0]          ch
    );
        logic [DATA_W-1:0] sample;
        sample = data[int'(ch) * DATA_W +: DATA_W];
        return {{PAD_W{1'b0}}, sample};
    endfunction

    // Synchronizer chains; index 0 is the newest sample, SYNC_STAGES-1 the oldest.
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] saddr_sync_q;

    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   s_saddr;

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]       rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0]       rise_num_s;
    logic [2:0]             addr_q, addr_d;
    logic [2:0]             addr_cap_s;
    logic [2:0]             cur_ch_q, cur_ch_d;
    logic [2:0]             next_ch_q, next_ch_d;
    logic                   sdat_q, sdat_d;
    logic                   frame_active_q, frame_active_d;
    logic                   frame_done_q, frame_done_d;

    // Shift the raw pins through the synchronizer chains (idle levels on reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q    <= {SYNC_STAGES{1'b1}};
            sclk_sync_q  <= {SYNC_STAGES{1'b1}};
            saddr_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
            saddr_sync_q <= {saddr_sync_q[SYNC_STAGES-2:0], ADC_SADDR};
        end
    end

    // Edge detection between the last two synchronizer stages.
    always_comb begin
        cs_fall_s   = cs_sync_q[SYNC_STAGES-1]   & ~cs_sync_q[SYNC_STAGES-2];
        cs_rise_s   = ~cs_sync_q[SYNC_STAGES-1]  &  cs_sync_q[SYNC_STAGES-2];
        sclk_rise_s = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_sync_q[SYNC_STAGES-2];
        sclk_fall_s = sclk_sync_q[SYNC_STAGES-1]  & ~sclk_sync_q[SYNC_STAGES-2];
        s_saddr     = saddr_sync_q[SYNC_STAGES-1];
    end

    // Rise number about to be counted, and the address with that rise's bit merged in.
    always_comb begin
        rise_num_s = rise_cnt_q + CNT_W'(1);
        addr_cap_s = addr_q;
        if (rise_num_s == CNT_W'(3)) begin
            addr_cap_s[2] = s_saddr;
        end else if (rise_num_s == CNT_W'(4)) begin
            addr_cap_s[1] = s_saddr;
        end else if (rise_num_s == CNT_W'(5)) begin
            addr_cap_s[0] = s_saddr;
        end else begin
            addr_cap_s = addr_q;
        end
    end

    // Frame FSM: next state, shift register, counters, channel tracking and output values.
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        rise_cnt_d     = rise_cnt_q;
        addr_d         = addr_q;
        cur_ch_d       = cur_ch_q;
        next_ch_d      = next_ch_q;
        frame_done_d   = 1'b0;
        sdat_d         = 1'b0;
        frame_active_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sdat_d         = 1'b0;
                frame_active_d = 1'b0;
                if (cs_fall_s) begin
                    shreg_d    = load_word(ch_data, next_ch_q);
                    cur_ch_d   = next_ch_q;
                    rise_cnt_d = '0;
                    addr_d     = 3'b000;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sdat_d         = shreg_q[FRAME_BITS-1];
                frame_active_d = 1'b1;
                // A CS_N rise takes priority over any SCLK edge in the same clock.
                if (cs_rise_s) begin
                    state_d    = ST_IDLE;
                    rise_cnt_d = '0;
                    addr_d     = 3'b000;
                end else if (sclk_rise_s) begin
                    if (rise_num_s == CNT_W'(FRAME_BITS)) begin
                        // Last rise: publish the address and start the next frame at once.
                        frame_done_d = 1'b1;
                        next_ch_d    = addr_cap_s;
                        cur_ch_d     = addr_cap_s;
                        shreg_d      = load_word(ch_data, addr_cap_s);
                        rise_cnt_d   = '0;
                        addr_d       = 3'b000;
                    end else begin
                        rise_cnt_d   = rise_num_s;
                        addr_d       = addr_cap_s;
                    end
                end else if (sclk_fall_s) begin
                    // The fall preceding the first rise must not consume the MSB.
                    if (rise_cnt_q != '0) begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    end else begin
                        shreg_d = shreg_q;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rise_cnt_d = '0;
                addr_d     = 3'b000;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            shreg_q        <= '0;
            rise_cnt_q     <= '0;
            addr_q         <= 3'b000;
            cur_ch_q       <= 3'b000;
            next_ch_q      <= 3'b000;
            sdat_q         <= 1'b0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            rise_cnt_q     <= rise_cnt_d;
            addr_q         <= addr_d;
            cur_ch_q       <= cur_ch_d;
            next_ch_q      <= next_ch_d;
            sdat_q         <= sdat_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign ADC_SDAT     = sdat_q;
    assign cur_ch       = cur_ch_q;
    assign next_ch      = next_ch_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: acts as the ADC reader. It drives CS_N and SCLK
// (8 clk period, SADDR changed on falls) and collects ADC_SDAT just before each rise.
// It compares the collected words and status outputs against hand-computed values.

module tb_adc_serial_responder;

    localparam int DATA_W = 12;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ADC_CS_N;
    logic                 ADC_SCLK;
    logic                 ADC_SADDR;
    logic [8*DATA_W-1:0]  ch_data;
    logic                 ADC_SDAT;
    logic [2:0]           cur_ch;
    logic [2:0]           next_ch;
    logic                 frame_active;
    logic                 frame_done;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] exp_word;
        logic [2:0]  exp_cur;
        logic [2:0]  exp_next;
    } vec_t;

    vec_t vecs [9];

    adc_serial_responder #(
        .DATA_W      (12),
        .FRAME_BITS  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ADC_CS_N     (ADC_CS_N),
        .ADC_SCLK     (ADC_SCLK),
        .ADC_SADDR    (ADC_SADDR),
        .ch_data      (ch_data),
        .ADC_SDAT     (ADC_SDAT),
        .cur_ch       (cur_ch),
        .next_ch      (next_ch),
        .frame_active (frame_active),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses.
    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cs_low();
        ADC_CS_N = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        ADC_CS_N = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Clock n_rises SCLK cycles; ch0 is rewritten to mid_val before sampling bit mid_at.
    task automatic run_frame(input logic [2:0] addr, input int n_rises, input int mid_at,
                             input logic [11:0] mid_val, output logic [15:0] word,
                             output logic [2:0] cur_mid, output logic act_all);
        logic [2:0] abits;
        abits   = addr;
        word    = 16'h0000;
        cur_mid = 3'b000;
        act_all = 1'b1;
        for (int i = 0; i < n_rises; i++) begin
            ADC_SCLK = 1'b0;
            if (i >= 2 && i <= 4) begin
                ADC_SADDR = abits[2];
                abits     = abits << 1;
            end else begin
                ADC_SADDR = 1'b0;
            end
            repeat (4) @(negedge clk);
            if (i == mid_at) ch_data[11:0] = mid_val;
            word    = {word[14:0], ADC_SDAT};
            act_all = act_all & frame_active;
            if (i == 0) cur_mid = cur_ch;
            ADC_SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin : main
        logic [15:0] w;
        logic [2:0]  cm;
        logic        act;
        int          d0;

        // Sweep table: frame k sends address k, returns channel k-1 (ch_data[i] = i*12'h111).
        vecs[0] = '{3'd0, 16'h0000, 3'd0, 3'd0};
        vecs[1] = '{3'd1, 16'h0000, 3'd0, 3'd1};
        vecs[2] = '{3'd2, 16'h0111, 3'd1, 3'd2};
        vecs[3] = '{3'd3, 16'h0222, 3'd2, 3'd3};
        vecs[4] = '{3'd4, 16'h0333, 3'd3, 3'd4};
        vecs[5] = '{3'd5, 16'h0444, 3'd4, 3'd5};
        vecs[6] = '{3'd6, 16'h0555, 3'd5, 3'd6};
        vecs[7] = '{3'd7, 16'h0666, 3'd6, 3'd7};
        vecs[8] = '{3'd0, 16'h0777, 3'd7, 3'd0};

        reset     = 1'b1;
        ADC_CS_N  = 1'b1;
        ADC_SCLK  = 1'b1;
        ADC_SADDR = 1'b0;
        ch_data   = '0;
        ch_data[0*DATA_W +: DATA_W] = 12'hA5C;
        ch_data[3*DATA_W +: DATA_W] = 12'hC9A;
        ch_data[5*DATA_W +: DATA_W] = 12'h3F1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_sdat",   32'(ADC_SDAT),     32'd0);
        check("rst_cur",    32'(cur_ch),       32'd0);
        check("rst_next",   32'(next_ch),      32'd0);
        check("rst_active", 32'(frame_active), 32'd0);
        check("rst_done",   32'(frame_done),   32'd0);

        // 1: single frame from channel 0.
        d0 = done_cnt;
        cs_low();
        run_frame(3'd0, 16, -1, 12'h000, w, cm, act);
        check("t1_word",   32'(w),   32'h0A5C);
        check("t1_cur",    32'(cm),  32'd0);
        check("t1_active", 32'(act), 32'd1);
        check("t1_done",   32'(done_cnt - d0), 32'd1);
        cs_high();
        check("t1_idle_active", 32'(frame_active), 32'd0);
        check("t1_idle_sdat",   32'(ADC_SDAT),     32'd0);

        // 2: address 5 in frame 1, frame 2 back-to-back returns ch5.
        d0 = done_cnt;
        cs_low();
        run_frame(3'd5, 16, -1, 12'h000, w, cm, act);
        check("t2_f1_word", 32'(w),      32'h0A5C);
        check("t2_f1_next", 32'(next_ch), 32'd5);
        run_frame(3'd5, 16, -1, 12'h000, w, cm, act);
        check("t2_f2_word", 32'(w),       32'h03F1);
        check("t2_f2_cur",  32'(cm),      32'd5);
        check("t2_f2_next", 32'(next_ch), 32'd5);
        check("t2_done",    32'(done_cnt - d0), 32'd2);
        cs_high();

        // Fresh frame after CS high uses next_ch=5; send address 0.
        cs_low();
        run_frame(3'd0, 16, -1, 12'h000, w, cm, act);
        check("t3_pre_word", 32'(w),       32'h03F1);
        check("t3_pre_next", 32'(next_ch), 32'd0);
        cs_high();

        // 3: abort after 4 rises with address 110 partly sent.
        d0 = done_cnt;
        cs_low();
        run_frame(3'd6, 4, -1, 12'h000, w, cm, act);
        check("t3_mid_active", 32'(act), 32'd1);
        cs_high();
        repeat (2) @(negedge clk);
        check("t3_sdat",   32'(ADC_SDAT),     32'd0);
        check("t3_active", 32'(frame_active), 32'd0);
        check("t3_done",   32'(done_cnt - d0), 32'd0);
        check("t3_next",   32'(next_ch),      32'd0);

        // 4: ch0 changes mid-frame; only the following frame sees it.
        ch_data[0*DATA_W +: DATA_W] = 12'h000;
        cs_low();
        run_frame(3'd0, 16, 6, 12'hFFF, w, cm, act);
        check("t4_f1_word", 32'(w), 32'h0000);
        run_frame(3'd0, 16, -1, 12'h000, w, cm, act);
        check("t4_f2_word", 32'(w), 32'h0FFF);
        cs_high();

        // 5: reset in the middle of a ch3 frame, after rise 9.
        cs_low();
        run_frame(3'd3, 16, -1, 12'h000, w, cm, act);
        check("t5_pre_word", 32'(w), 32'h0FFF);
        cs_high();
        cs_low();
        run_frame(3'd0, 9, -1, 12'h000, w, cm, act);
        check("t5_mid_cur",    32'(cur_ch),       32'd3);
        check("t5_mid_active", 32'(frame_active), 32'd1);
        check("t5_mid_sdat",   32'(ADC_SDAT),     32'd1);
        check("t5_mid_next",   32'(next_ch),      32'd3);
        reset     = 1'b1;
        #1;
        check("t5_rst_sdat",   32'(ADC_SDAT),     32'd0);
        check("t5_rst_cur",    32'(cur_ch),       32'd0);
        check("t5_rst_next",   32'(next_ch),      32'd0);
        check("t5_rst_active", 32'(frame_active), 32'd0);
        check("t5_rst_done",   32'(frame_done),   32'd0);
        ADC_CS_N  = 1'b1;
        ADC_SCLK  = 1'b1;
        ADC_SADDR = 1'b0;
        ch_data[0*DATA_W +: DATA_W] = 12'h5A3;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        cs_low();
        run_frame(3'd0, 16, -1, 12'h000, w, cm, act);
        check("t5_post_word", 32'(w),  32'h05A3);
        check("t5_post_cur",  32'(cm), 32'd0);
        cs_high();

        // 6: continuous sweep of all eight addresses.
        for (int i = 0; i < 8; i++) begin
            ch_data[i*DATA_W +: DATA_W] = 12'(i * 12'h111);
        end
        d0 = done_cnt;
        cs_low();
        for (int k = 0; k < 9; k++) begin
            run_frame(vecs[k].addr, 16, -1, 12'h000, w, cm, act);
            check($sformatf("t6_word_%0d", k), 32'(w),       32'(vecs[k].exp_word));
            check($sformatf("t6_cur_%0d", k),  32'(cm),      32'(vecs[k].exp_cur));
            check($sformatf("t6_next_%0d", k), 32'(next_ch), 32'(vecs[k].exp_next));
        end
        check("t6_done", 32'(done_cnt - d0), 32'd9);
        cs_high();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
